// File: rtl/test_ff_pkg.sv
// Shared definitions for the test_ff pipeline: the op encoding and the op
// evaluation function. The RTL and the reference model both call op_eval, so
// the op semantics live in one place.
`timescale 1ns/1ps
package test_ff_pkg;

  typedef enum logic [1:0] {
    OP_AND    = 2'd0,
    OP_OR     = 2'd1,
    OP_XOR    = 2'd2,
    OP_CLRMUX = 2'd3
  } op_t;

  // Widest operand op_eval handles. Callers zero-extend their operands to this
  // width and truncate the result back to their own width. None of the ops
  // move bits between positions, so truncating gives the same answer as
  // computing at the narrow width.
  localparam int OP_MAX_W = 64;

  function automatic logic [OP_MAX_W-1:0] op_eval(
    input op_t                 op,
    input logic [OP_MAX_W-1:0] a,
    input logic [OP_MAX_W-1:0] b,
    input logic                ctrl
  );
    logic [OP_MAX_W-1:0] r;
    case (op)
      OP_AND:    r = a & b;
      OP_OR:     r = a | b;
      OP_XOR:    r = a ^ b;
      OP_CLRMUX: r = ctrl ? '0 : a;
      default:   r = '0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/test_ff_stage.sv
// One stage of the elastic pipeline: a valid flag and a data register.
// The stage can take a new beat when it is empty, or when the stage after it
// is taking its current beat.
// Ports:
//   clk      in   clock, posedge
//   rst      in   asynchronous active-high reset
//   clr      in   synchronous flush (clears valid, reloads RESET_VAL)
//   v_in     in   valid of the beat offered from upstream
//   d_in     in   data of the beat offered from upstream
//   rdy_in   in   downstream stage (or consumer) can take this stage's beat
//   rdy_out  out  this stage can load this cycle
//   v_out    out  stage holds a valid beat
//   d_out    out  stage data
`timescale 1ns/1ps
module test_ff_stage #(
  parameter int             N         = 4,
  parameter logic [N-1:0]   RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         v_in,
  input  logic [N-1:0] d_in,
  input  logic         rdy_in,
  output logic         rdy_out,
  output logic         v_out,
  output logic [N-1:0] d_out
);

  assign rdy_out = !v_out | rdy_in;

  // NOTE: sequential state is written only with non-blocking assignments, so
  // every stage samples the value its neighbour held before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_out <= 1'b0;
      // NOTE: the data register is reset as well as the valid flag, so its
      // value is never X, not even while the stage is empty.
      d_out <= RESET_VAL;
    end else if (clr) begin
      v_out <= 1'b0;
      d_out <= RESET_VAL;
    end else if (rdy_out) begin
      v_out <= v_in;
      // When a bubble moves in, the old data stays in place.
      if (v_in) d_out <= d_in;
    end
  end

endmodule

// File: rtl/test_ff_pipe.sv
// Op unit (AND/OR/XOR/clear-mux) feeding a DEPTH-stage elastic pipeline with
// a valid/ready handshake, a synchronous flush and an occupancy count.
// Ports:
//   clk        in   clock, posedge
//   rst        in   asynchronous active-high reset
//   IN_valA    in   operand A
//   IN_valB    in   operand B
//   IN_valC    in   operand C (reserved, not used by any op)
//   IN_ctrl    in   clear select for OP_CLRMUX
//   IN_op      in   op select (test_ff_pkg::op_t encoding)
//   IN_valid   in   input beat valid
//   OUT_ready  out  input beat accepted when IN_valid & OUT_ready
//   IN_clr     in   synchronous flush
//   OUT_valA   out  last-stage data
//   OUT_valid  out  last-stage valid
//   IN_ready   in   downstream takes the beat when OUT_valid & IN_ready
//   OUT_count  out  number of valid stages
`timescale 1ns/1ps
module test_ff_pipe
  import test_ff_pkg::*;
#(
  parameter int           N         = 4,
  parameter int           DEPTH     = 2,
  parameter logic [N-1:0] RESET_VAL = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N-1:0]               IN_valA,
  input  logic [N-1:0]               IN_valB,
  input  logic [N-1:0]               IN_valC,
  input  logic                       IN_ctrl,
  input  logic [1:0]                 IN_op,
  input  logic                       IN_valid,
  output logic                       OUT_ready,
  input  logic                       IN_clr,
  output logic [N-1:0]               OUT_valA,
  output logic                       OUT_valid,
  input  logic                       IN_ready,
  output logic [$clog2(DEPTH+1)-1:0] OUT_count
);

  localparam int CW = $clog2(DEPTH+1);

  if (DEPTH < 1) begin : g_bad_depth
    $error("test_ff_pipe: DEPTH must be >= 1");
  end

  logic         accept;
  logic         deliver;
  logic [N-1:0] op_res;
  logic         unused_valc;

  assign unused_valc = ^IN_valC;

  assign op_res = N'(op_eval(op_t'(IN_op), OP_MAX_W'(IN_valA),
                             OP_MAX_W'(IN_valB), IN_ctrl));

  // Each stage keeps its own ready wire in its generate block. Stage k reads
  // the ready of stage k+1 by name. This keeps the ready chain (which passes
  // through combinational logic) out of one shared vector.
  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    logic         v_in;
    logic [N-1:0] d_in;
    logic         rdy_in;
    logic         rdy;
    logic         v;
    logic [N-1:0] q;

    if (k == 0) begin : g_head
      assign v_in = accept;
      assign d_in = op_res;
    end else begin : g_link
      assign v_in = g_stage[k-1].v;
      assign d_in = g_stage[k-1].q;
    end

    if (k == DEPTH - 1) begin : g_tail
      assign rdy_in = IN_ready;
    end else begin : g_mid
      assign rdy_in = g_stage[k+1].rdy;
    end

    test_ff_stage #(
      .N         (N),
      .RESET_VAL (RESET_VAL)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .clr     (IN_clr),
      .v_in    (v_in),
      .d_in    (d_in),
      .rdy_in  (rdy_in),
      .rdy_out (rdy),
      .v_out   (v),
      .d_out   (q)
    );
  end

  // A flush blocks new beats. A beat leaving on the same edge still counts as
  // delivered.
  assign OUT_ready = g_stage[0].rdy & !IN_clr;
  assign accept    = IN_valid & OUT_ready;
  assign OUT_valid = g_stage[DEPTH-1].v;
  assign OUT_valA  = g_stage[DEPTH-1].q;
  assign deliver   = OUT_valid & IN_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      OUT_count <= '0;
    end else if (IN_clr) begin
      OUT_count <= '0;
    end else begin
      case ({accept, deliver})
        2'b10:   OUT_count <= OUT_count + CW'(1);
        2'b01:   OUT_count <= OUT_count - CW'(1);
        default: OUT_count <= OUT_count;
      endcase
    end
  end

endmodule
